// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Only one operation is in flight at a time: IDLE accepts, EXEC lets the ALU settle, RESP holds the result.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [3:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [3:0]        rsp1_flags,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  input  logic              alu_negative,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state, state_nxt;
  logic                     last_grant;
  logic                     owner;
  logic                     grant;
  logic                     accept;
  logic                     rsp_done;
  logic [1:0]               rsp_valid_q;
  logic [1:0][DATA_W-1:0]   rsp_result_q;
  logic [1:0][3:0]          rsp_flags_q;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
        // Ready is masked during reset so a requester never sees an accept that reset discards.
        accept     = (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_done = owner ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: response slots are reset too, because their reset value of zero is architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner  <= grant;
          alu_op <= grant ? req1_op : req0_op;
          alu_a  <= grant ? req1_a  : req0_a;
          alu_b  <= grant ? req1_b  : req0_b;
        end
        EXEC: begin
          rsp_result_q[owner] <= alu_result;
          rsp_flags_q[owner]  <= {alu_zero, alu_overflow, alu_carry, alu_negative};
          rsp_valid_q[owner]  <= 1'b1;
        end
        RESP: if (rsp_done) begin
          rsp_valid_q[owner] <= 1'b0;
          last_grant         <= owner;
          op_count           <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign rsp0_flags  = rsp_flags_q[0];
  assign rsp1_flags  = rsp_flags_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
// The counter is built 4 bits wide so its wrap is reachable in a short run.
module tb_alu_arbiter;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int CNT_W  = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic [3:0]        rsp0_flags, rsp1_flags;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_zero, alu_overflow, alu_carry, alu_negative;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry), .alu_negative(alu_negative),
    .busy(busy), .op_count(op_count)
  );

  // Behavioural ALU: carry is carry-out for ADD and no-borrow for SUB.
  always_comb begin
    logic [DATA_W:0] wide;
    wide         = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry    = wide[DATA_W];
        alu_overflow = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (wide[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        wide         = {1'b0, alu_a - alu_b};
        alu_carry    = (alu_a >= alu_b);
        alu_overflow = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (wide[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_AND:  wide = {1'b0, alu_a & alu_b};
      OP_OR:   wide = {1'b0, alu_a | alu_b};
      OP_XOR:  wide = {1'b0, alu_a ^ alu_b};
      default: wide = {1'b0, alu_a};
    endcase
    alu_result   = wide[DATA_W-1:0];
    alu_zero     = (alu_result == '0);
    alu_negative = alu_result[DATA_W-1];
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  // Leaves rst high across two edges; the caller releases it at a falling edge.
  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    clear_inputs();
    hold_reset();
    rst = 1'b0;
  endtask

  // Waits at falling edges until the given response valid is seen; n = -1 on timeout.
  task automatic wait_rsp(input int idx, output int n);
    n = -1;
    for (int i = 0; i < 12; i++) begin
      if ((idx == 0 && rsp0_valid) || (idx == 1 && rsp1_valid)) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One complete req0 transaction with immediate response acceptance; ok = 0 on timeout.
  task automatic run_req0(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic [3:0] fl, output logic ok);
    int n;
    ok = 1'b0; res = '0; fl = '0;
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    if (ok) begin
      wait_rsp(0, n);
      ok = (n >= 0);
      res = rsp0_result;
      fl  = rsp0_flags;
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    req0_valid = 1'b1;
    hold_reset();
    #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", req0_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", {rsp0_valid, rsp1_valid}); end
    total++; if ({alu_op, alu_a, alu_b} !== 20'h0) begin bad++; $display("FAIL reset_alu_regs got=%h want=0", {alu_op, alu_a, alu_b}); end
    total++; if ({rsp0_result, rsp0_flags, rsp1_result, rsp1_flags} !== 24'h0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", {rsp0_result, rsp0_flags, rsp1_result, rsp1_flags}); end
    total++; if (op_count !== 4'd0) begin bad++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    pulse_reset();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h7F; req0_b = 8'h01;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    total++; if ({busy, rsp0_valid, alu_op, alu_a, alu_b} !== {2'b10, OP_ADD, 8'h7F, 8'h01}) begin bad++; $display("FAIL single_exec got=%h want=%h", {busy, rsp0_valid, alu_op, alu_a, alu_b}, {2'b10, OP_ADD, 8'h7F, 8'h01}); end
    @(negedge clk);
    wait_rsp(0, n);
    total++; if (n !== 0) begin bad++; $display("FAIL single_latency got=%0d want=0 extra cycles", n); end
    total++; if ({rsp0_result, rsp0_flags} !== {8'h80, 4'b0101}) begin bad++; $display("FAIL single_result got=%h/%b want=80/0101", rsp0_result, rsp0_flags); end
    total++; if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp1_valid got=%b want=0", rsp1_valid); end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    total++; if ({busy, rsp0_valid, op_count} !== {2'b00, 4'd1}) begin bad++; $display("FAIL single_done got=%b/%b/%0d want=0/0/1", busy, rsp0_valid, op_count); end
  endtask

  task automatic test_tie();
    int n;
    pulse_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 8'h05; req0_b = 8'h05;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 8'hF0; req1_b = 8'h0F;
    #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie_first_grant got=%b want=10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_ready_exec got=%b want=0", req1_ready); end
    wait_rsp(0, n);
    total++; if (n < 0 || {rsp0_result, rsp0_flags} !== {8'h00, 4'b1010}) begin bad++; $display("FAIL tie_rsp0 got=%h/%b wait=%0d want=00/1010", rsp0_result, rsp0_flags, n); end
    @(negedge clk);
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL tie_second_grant got=%b want=1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(1, n);
    total++; if (n < 0 || {rsp1_result, rsp1_flags, rsp0_valid} !== {8'hFF, 4'b0001, 1'b0}) begin bad++; $display("FAIL tie_rsp1 got=%h/%b/%b wait=%0d want=ff/0001/0", rsp1_result, rsp1_flags, rsp0_valid, n); end
    @(negedge clk);
    total++; if ({busy, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL tie_idle got=%b want=00", {busy, rsp1_valid}); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int n;
    logic [11:0] held;
    pulse_reset();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h10; req0_b = 8'h22;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 8'h0C; req1_b = 8'h30;
    wait_rsp(0, n);
    held = {rsp0_result, rsp0_flags};
    total++; if (n < 0 || held !== {8'h32, 4'b0000}) begin bad++; $display("FAIL bp_result got=%h wait=%0d want=320", held, n); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      total++;
      if ({rsp0_valid, rsp0_result, rsp0_flags, req1_ready, busy} !== {1'b1, held, 2'b01}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got=%b/%h/%b/%b want=1/%h/0/1", i, rsp0_valid, {rsp0_result, rsp0_flags}, req1_ready, busy, held);
      end
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    total++; if ({busy, rsp0_valid, req1_ready} !== 3'b001) begin bad++; $display("FAIL bp_release got=%b want=001", {busy, rsp0_valid, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    total++; if ({busy, alu_op, alu_a, alu_b} !== {1'b1, OP_OR, 8'h0C, 8'h30}) begin bad++; $display("FAIL bp_req1_accept got=%h want=%h", {busy, alu_op, alu_a, alu_b}, {1'b1, OP_OR, 8'h0C, 8'h30}); end
    wait_rsp(1, n);
    total++; if (n < 0 || {rsp1_result, rsp1_flags} !== {8'h3C, 4'b0000}) begin bad++; $display("FAIL bp_rsp1 got=%h/%b wait=%0d want=3c/0000", rsp1_result, rsp1_flags, n); end
    rsp1_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_fairness();
    int order[6];
    int when[6];
    int seen;
    pulse_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 8'h03; req1_b = 8'h04;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
      @(negedge clk);
      total++; if (rsp0_valid && rsp1_valid) begin bad++; $display("FAIL fair_one_hot cycle=%0d got=11 want=one valid at most", cyc); end
      if (rsp0_valid || rsp1_valid) begin
        order[seen] = rsp1_valid ? 1 : 0;
        when[seen]  = cyc;
        seen++;
      end
    end
    total++; if (seen !== 6) begin bad++; $display("FAIL fair_count got=%0d want=6", seen); end
    for (int i = 0; i < seen; i++) begin
      total++; if (order[i] !== (i % 2)) begin bad++; $display("FAIL fair_order op=%0d got=%0d want=%0d", i, order[i], i % 2); end
      if (i > 0) begin
        total++; if (when[i] - when[i-1] !== 3) begin bad++; $display("FAIL fair_spacing op=%0d got=%0d want=3", i, when[i] - when[i-1]); end
      end
    end
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int n;
    pulse_reset();
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 8'hAA; req0_b = 8'h0F;
    @(negedge clk);
    rst = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_in_exec got=%b want=1", busy); end
    @(negedge clk);
    total++; if ({rsp0_valid, rsp0_result, rsp0_flags, busy, op_count} !== 19'h0) begin bad++; $display("FAIL rst_mid_rsp got=%h want=0", {rsp0_valid, rsp0_result, rsp0_flags, busy, op_count}); end
    total++; if ({alu_op, alu_a, alu_b, req0_ready, req1_ready} !== 22'h0) begin bad++; $display("FAIL rst_mid_alu got=%h want=0", {alu_op, alu_a, alu_b, req0_ready, req1_ready}); end
    rst = 1'b0;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_rearb got=%b want=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(0, n);
    total++; if (n < 0 || {rsp0_result, rsp0_flags} !== {8'h0A, 4'b0000}) begin bad++; $display("FAIL rst_mid_result got=%h/%b wait=%0d want=0a/0000", rsp0_result, rsp0_flags, n); end
    rsp0_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_counter_wrap();
    logic [7:0] res;
    logic [3:0] fl;
    logic       ok;
    int         fails;
    pulse_reset();
    fails = 0;
    for (int i = 0; i < 16; i++) begin
      run_req0(OP_ADD, 8'(i), 8'h01, res, fl, ok);
      if (!ok || res !== 8'(i + 1)) fails++;
    end
    total++; if (fails !== 0) begin bad++; $display("FAIL wrap_ops got=%0d bad ops want=0", fails); end
    total++; if (op_count !== 4'd0) begin bad++; $display("FAIL wrap_16 got=%0d want=0", op_count); end
    run_req0(OP_SUB, 8'h03, 8'h05, res, fl, ok);
    total++; if (!ok || {res, fl} !== {8'hFE, 4'b0001}) begin bad++; $display("FAIL wrap_op17 got=%h/%b ok=%b want=fe/0001", res, fl, ok); end
    total++; if (op_count !== 4'd1) begin bad++; $display("FAIL wrap_17 got=%0d want=1", op_count); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_fairness();
    test_reset_mid_op();
    test_counter_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
